// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory access arbiter.
package dm_arb_pkg;

  localparam int unsigned DM_AW    = 16;
  localparam int unsigned DM_DW    = 16;
  localparam int unsigned STARVE_W = 4;

  // Which requester owns the DM port in a given cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_MEM  = 2'b01,
    OWN_AUX  = 2'b10
  } owner_t;

  // Tag carried alongside each DM access until its read data returns.
  typedef struct packed {
    logic   is_read;
    owner_t owner;
  } rd_tag_t;

  // True when a returning tag is a read belonging to the given owner.
  function automatic logic tag_hits(input rd_tag_t t, input owner_t o);
    return t.is_read && (t.owner == o);
  endfunction

endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating count of consecutive cycles the AUX requester was denied.
// Asserts forced once the count reaches max while the request is still up.
import dm_arb_pkg::*;

module dm_arb_starve_ctr (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                gnt,
  input  logic [STARVE_W-1:0] max,
  output logic [STARVE_W-1:0] cnt,
  output logic                forced
);

  logic [STARVE_W-1:0] r_cnt;

  // Count denied cycles; any grant or dropped request restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (gnt || !req) begin
      r_cnt <= '0;
    end else if (r_cnt != max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt    = r_cnt;
  assign forced = req && (r_cnt == max);

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares the single-ported data memory between the pipeline MEM stage
// (priority) and the AUX loader/debug port, with a starvation override
// and owner-tagged read-data return.
import dm_arb_pkg::*;

module dm_access_arbiter #(
  parameter int unsigned AW         = DM_AW,
  parameter int unsigned DW         = DM_DW,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          mem_re,
  input  logic          mem_we,
  output logic          mem_stall,
  output logic          mem_rvalid,
  output logic [DW-1:0] mem_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_gnt,
  output logic          aux_rvalid,
  output logic [DW-1:0] aux_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_in,
  output logic          dm_re,
  output logic          dm_we,
  input  logic [DW-1:0] dm_out
);

  localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_MAX);

  logic                w_mem_act;
  logic                w_mem_rd;
  logic                w_aux_rd;
  logic                w_force;
  logic [STARVE_W-1:0] w_starve_cnt;
  owner_t              w_owner;
  rd_tag_t             w_tag_in;
  rd_tag_t             w_tag_out;
  logic                w_aux_ret;

  rd_tag_t [RD_LAT-1:0] r_tag_pipe;
  logic [DW-1:0]        r_aux_rdata;
  logic                 r_aux_rvalid;

  // A simultaneous read and write from MEM is treated as a write only.
  assign w_mem_act = mem_re | mem_we;
  assign w_mem_rd  = mem_re & ~mem_we;
  assign w_aux_rd  = ~aux_we;

  dm_arb_starve_ctr u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (aux_req),
    .gnt    (aux_gnt),
    .max    (LP_STARVE_MAX),
    .cnt    (w_starve_cnt),
    .forced (w_force)
  );

  // Pick the DM owner: a starved AUX beats MEM, otherwise MEM beats AUX.
  always_comb begin
    w_owner = OWN_NONE;
    if (w_force) begin
      w_owner = OWN_AUX;
    end else if (w_mem_act) begin
      w_owner = OWN_MEM;
    end else if (aux_req) begin
      w_owner = OWN_AUX;
    end
  end

  // Steer the winning requester onto the DM port and report grant/stall.
  always_comb begin
    dm_addr   = '0;
    dm_in     = '0;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    aux_gnt   = 1'b0;
    mem_stall = 1'b0;
    w_tag_in  = '{is_read: 1'b0, owner: OWN_NONE};
    case (w_owner)
      OWN_MEM: begin
        dm_addr  = mem_addr;
        dm_in    = mem_wdata;
        dm_re    = w_mem_rd;
        dm_we    = mem_we;
        w_tag_in = '{is_read: w_mem_rd, owner: OWN_MEM};
      end
      OWN_AUX: begin
        dm_addr   = aux_addr;
        dm_in     = aux_wdata;
        dm_re     = w_aux_rd;
        dm_we     = aux_we;
        aux_gnt   = 1'b1;
        mem_stall = w_mem_act;
        w_tag_in  = '{is_read: w_aux_rd, owner: OWN_AUX};
      end
      default: ;
    endcase
  end

  // Tag shift register: one stage per cycle of DM read latency.
  // Split by depth so the single-stage case needs no part-select.
  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_tag_pipe <= '0;
        end else begin
          r_tag_pipe <= w_tag_in;
        end
      end
    end else begin : g_latn
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_tag_pipe <= '0;
        end else begin
          r_tag_pipe <= {r_tag_pipe[RD_LAT-2:0], w_tag_in};
        end
      end
    end
  endgenerate

  assign w_tag_out = r_tag_pipe[RD_LAT-1];
  assign w_aux_ret = tag_hits(w_tag_out, OWN_AUX);

  // MEM read data passes straight through in the cycle DM presents it.
  assign mem_rvalid = tag_hits(w_tag_out, OWN_MEM);
  assign mem_rdata  = dm_out;

  // Capture AUX read data; the valid pulse follows the cycle it lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_aux_rdata  <= '0;
      r_aux_rvalid <= 1'b0;
    end else begin
      r_aux_rvalid <= w_aux_ret;
      if (w_aux_ret) begin
        r_aux_rdata <= dm_out;
      end
    end
  end

  assign aux_rdata  = r_aux_rdata;
  assign aux_rvalid = r_aux_rvalid;

endmodule
